// File: rtl/fixed_pkg.sv
// Shared definitions for the fixed-point arithmetic units (multiplier, divider):
// FSM state encoding, counter sizing and width-parameterised saturation limits.
package fixed_pkg;

    // Sequencing states shared by the multiply and divide units
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } fixed_state_e;

    // Saturation constants are produced in a wide container and sliced by the
    // caller. The container holds a 2*DATA_WIDTH magnitude, so DATA_WIDTH <= 64.
    localparam int WIDE_W         = 128;
    localparam int MAX_DATA_WIDTH = 64;

    // Width of a counter that walks 0 .. w-1
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Largest positive value of a w-bit two's complement number: 2^(w-1)-1
    function automatic logic [WIDE_W-1:0] sat_max_pos(input int w);
        logic [WIDE_W-1:0] one;
        one = 128'd1;
        return (one << (w - 1)) - one;
    endfunction

    // Most negative w-bit value as a bit pattern (0x80..0); numerically this is
    // also the largest magnitude a negative result may carry: 2^(w-1)
    function automatic logic [WIDE_W-1:0] sat_min_neg(input int w);
        logic [WIDE_W-1:0] one;
        one = 128'd1;
        return one << (w - 1);
    endfunction

endpackage

// File: rtl/fixed_mul_if.sv
// Request/response bundle of the fixed-point multiplier. The controller side
// (master) issues start with operands; the unit side (slave) reports ready,
// complete and the saturated product.
interface fixed_mul_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  ready;
    logic                  complete;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] prod;
    logic                  overflow;

    modport master (
        output start, a, b,
        input  ready, complete, prod, overflow
    );

    modport slave (
        input  start, a, b,
        output ready, complete, prod, overflow
    );
endinterface

// File: rtl/fixed_sat.sv
// Magnitude -> signed conversion with saturation. Takes an unsigned magnitude
// (wider than the result) plus a sign and returns the DATA_WIDTH two's
// complement value, clamped to the representable range, with an overflow flag.
// A zero magnitude always yields +0 regardless of sign.
module fixed_sat
    import fixed_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAG_WIDTH  = 64
) (
    input  logic [MAG_WIDTH-1:0]  mag_i,
    input  logic                  neg_i,
    output logic [DATA_WIDTH-1:0] val_o,
    output logic                  ovf_o
);
    localparam logic [WIDE_W-1:0] MAX_POS_WIDE = sat_max_pos(DATA_WIDTH);
    localparam logic [WIDE_W-1:0] MIN_NEG_WIDE = sat_min_neg(DATA_WIDTH);

    // Magnitude limits: 2^(W-1)-1 for positive, 2^(W-1) for negative results
    localparam logic [MAG_WIDTH-1:0]  POS_LIM = MAX_POS_WIDE[MAG_WIDTH-1:0];
    localparam logic [MAG_WIDTH-1:0]  NEG_LIM = MIN_NEG_WIDE[MAG_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] MAX_POS = MAX_POS_WIDE[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = MIN_NEG_WIDE[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] mag_lo_s;

    assign mag_lo_s = mag_i[DATA_WIDTH-1:0];

    // Clamp the magnitude against the sign-dependent limit and apply the sign
    always_comb begin
        val_o = '0;
        ovf_o = 1'b0;
        if (neg_i) begin
            if (mag_i > NEG_LIM) begin
                val_o = MIN_NEG;
                ovf_o = 1'b1;
            end else begin
                // -(2^(W-1)) wraps onto itself, which is the correct pattern
                val_o = '0 - mag_lo_s;
                ovf_o = 1'b0;
            end
        end else begin
            if (mag_i > POS_LIM) begin
                val_o = MAX_POS;
                ovf_o = 1'b1;
            end else begin
                val_o = mag_lo_s;
                ovf_o = 1'b0;
            end
        end
    end
endmodule

// File: rtl/fixed_mul.sv
// Sequential signed fixed-point multiplier. Operands are converted to sign +
// magnitude on capture, multiplied with a radix-2 shift-add datapath (one
// multiplier bit per cycle, LSB first, fixed DATA_WIDTH-cycle latency), then
// the product is rescaled by BIN_POS (truncating the magnitude, i.e. rounding
// toward zero) and saturated into DATA_WIDTH bits.
module fixed_mul
    import fixed_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BIN_POS    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    fixed_mul_if.slave  bus
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = cnt_width(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    fixed_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sign_q;
    logic [2*W-1:0]   mcand_q;
    logic [W-1:0]     mplier_q;
    logic [2*W-1:0]   acc_q;
    logic [W-1:0]     prod_q;
    logic             ovf_q;
    logic             ready_q;
    logic             complete_q;

    logic [W-1:0]     mag_a_s;
    logic [W-1:0]     mag_b_s;
    logic [2*W-1:0]   acc_d;
    logic [2*W-1:0]   quot_s;
    logic [W-1:0]     sat_val_s;
    logic             sat_ovf_s;

    // Operand magnitudes; W-bit unsigned so |0x80..0| = 2^(W-1) fits
    always_comb begin
        mag_a_s = bus.a;
        mag_b_s = bus.b;
        if (bus.a[W-1]) begin
            mag_a_s = '0 - bus.a;
        end else begin
            mag_a_s = bus.a;
        end
        if (bus.b[W-1]) begin
            mag_b_s = '0 - bus.b;
        end else begin
            mag_b_s = bus.b;
        end
    end

    // Accumulator after the current multiplier bit has been applied
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end else begin
            acc_d = acc_q;
        end
    end

    // Rescale to the fixed-point format; dropping low bits truncates the magnitude
    assign quot_s = acc_d >> BIN_POS;

    fixed_sat #(
        .DATA_WIDTH (W),
        .MAG_WIDTH  (2 * W)
    ) u_sat (
        .mag_i (quot_s),
        .neg_i (sign_q),
        .val_o (sat_val_s),
        .ovf_o (sat_ovf_s)
    );

    // Control FSM with datapath registers and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            prod_q     <= '0;
            ovf_q      <= 1'b0;
            ready_q    <= 1'b1;
            complete_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        sign_q   <= bus.a[W-1] ^ bus.b[W-1];
                        mcand_q  <= {{W{1'b0}}, mag_a_s};
                        mplier_q <= mag_b_s;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        ready_q  <= 1'b0;
                        state_q  <= ST_CALC;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    // Zero operands still run all W steps so latency is fixed
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    if (cnt_q == CNT_LAST) begin
                        prod_q     <= sat_val_s;
                        ovf_q      <= sat_ovf_s;
                        complete_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end else begin
                        cnt_q      <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    // Hold the result until start is released; never restart here
                    if (!bus.start) begin
                        complete_q <= 1'b0;
                        ready_q    <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else begin
                        state_q    <= ST_DONE;
                    end
                end
                default: begin
                    complete_q <= 1'b0;
                    ready_q    <= 1'b1;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.complete = complete_q;
    assign bus.prod     = prod_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_fixed_mul.sv
// Bench for fixed_mul (W=32, BIN_POS=16): directed vectors, reset abort,
// handshake behaviour and seeded random operands against an arithmetic model.
module tb_fixed_mul;
    localparam int W  = 32;
    localparam int BP = 16;
    localparam int NVEC = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fixed_mul_if #(.DATA_WIDTH(W)) bus ();

    fixed_mul #(
        .DATA_WIDTH (W),
        .BIN_POS    (BP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    localparam logic [W-1:0] VA [NVEC] = '{
        32'h0001_8000, 32'hFFFF_8000, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
        32'h0000_0003, 32'h0100_0000, 32'hFF00_0000, 32'hFFFF_0000};
    localparam logic [W-1:0] VB [NVEC] = '{
        32'h0002_0000, 32'h0003_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_8000,
        32'h0000_8000, 32'h0100_0000, 32'h0100_0000, 32'h8000_0000};
    localparam logic [W-1:0] VP [NVEC] = '{
        32'h0003_0000, 32'hFFFE_8000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    localparam logic VO [NVEC] = '{
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    // Reference: exact signed product, divided (truncating toward zero) by 2^BP, then clamped
    function automatic void ref_mul(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                    output logic [W-1:0] p, output logic o);
        longint pa;
        longint pb;
        longint q;
        pa = $signed(a_v);
        pb = $signed(b_v);
        q  = (pa * pb) / (64'sd1 <<< BP);
        if (q > 64'sd2147483647) begin
            p = 32'h7FFF_FFFF;
            o = 1'b1;
        end else if (q < -64'sd2147483648) begin
            p = 32'h8000_0000;
            o = 1'b1;
        end else begin
            p = q[W-1:0];
            o = 1'b0;
        end
    endfunction

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] ext [6];
        int unsigned  m;
        ext = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000,
                32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_0000};
        m = $urandom_range(0, 3);
        if (m == 0) return ext[$urandom_range(0, 5)];
        if (m == 1) return W'($signed($urandom_range(0, 32'h001F_FFFF)) - 32'sh0010_0000);
        return $urandom;
    endfunction

    // One full operation: capture, optional operand scrambling during CALC,
    // wait (bounded) for complete, then release start and let it return to IDLE
    task automatic run_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input bit scramble,
                          output logic [W-1:0] p, output logic o, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a_v;
        bus.b     = b_v;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (lat < 100) begin
            if (scramble) begin
                bus.a = $urandom;
                bus.b = $urandom;
            end
            @(posedge clk);
            lat++;
            #1;
            if (bus.complete === 1'b1) break;
            @(negedge clk);
        end
        p = bus.prod;
        o = bus.overflow;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;
        #12;
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.ready); end
        total++; if (bus.complete !== 1'b0) begin bad++; $display("FAIL reset_complete got=%b want=0", bus.complete); end
        total++; if (bus.prod !== 32'h0) begin bad++; $display("FAIL reset_prod got=%h want=00000000", bus.prod); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.overflow); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [W-1:0] p;
        logic         o;
        int           lat;
        for (int i = 0; i < NVEC; i++) begin
            run_op(VA[i], VB[i], 1'b0, p, o, lat);
            total++; if (p !== VP[i]) begin bad++; $display("FAIL vec%0d_prod got=%h want=%h", i, p, VP[i]); end
            total++; if (o !== VO[i]) begin bad++; $display("FAIL vec%0d_ovf got=%b want=%b", i, o, VO[i]); end
            total++; if (lat !== 32) begin bad++; $display("FAIL vec%0d_latency got=%0d want=32", i, lat); end
            total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL vec%0d_ready_back got=%b want=1", i, bus.ready); end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] p;
        logic         o;
        int           lat;
        bit           seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h0001_8000;
        bus.b     = 32'h0002_0000;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", bus.ready); end
        total++; if (bus.complete !== 1'b0) begin bad++; $display("FAIL midrst_complete got=%b want=0", bus.complete); end
        total++; if (bus.prod !== 32'h0) begin bad++; $display("FAIL midrst_prod got=%h want=00000000", bus.prod); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.complete !== 1'b0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_pulse got=%b want=0", seen); end
        run_op(32'h0001_8000, 32'h0002_0000, 1'b0, p, o, lat);
        total++; if (p !== 32'h0003_0000) begin bad++; $display("FAIL midrst_next_prod got=%h want=00030000", p); end
    endtask

    task automatic test_hold_start();
        int lat;
        bit stable;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'hFFFF_8000;
        bus.b     = 32'h0003_0000;
        @(posedge clk);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.complete === 1'b1) break;
        end
        total++; if (lat !== 32) begin bad++; $display("FAIL hold_latency got=%0d want=32", lat); end
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.complete !== 1'b1 || bus.ready !== 1'b0 || bus.prod !== 32'hFFFE_8000) stable = 1'b0;
        end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL hold_stable got=%b want=1 (complete=%b prod=%h)", stable, bus.complete, bus.prod); end
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL drop_ready got=%b want=1", bus.ready); end
        total++; if (bus.complete !== 1'b0) begin bad++; $display("FAIL drop_complete got=%b want=0", bus.complete); end
    endtask

    task automatic test_operand_change();
        logic [W-1:0] p;
        logic         o;
        int           lat;
        run_op(32'h0001_8000, 32'h0002_0000, 1'b1, p, o, lat);
        total++; if (p !== 32'h0003_0000) begin bad++; $display("FAIL opchange_prod got=%h want=00030000", p); end
        total++; if (o !== 1'b0) begin bad++; $display("FAIL opchange_ovf got=%b want=0", o); end
    endtask

    task automatic test_random();
        logic [W-1:0] a_v, b_v, p, ep;
        logic         o, eo;
        int           lat;
        void'($urandom(32'd20240611));
        for (int i = 0; i < 1000; i++) begin
            a_v = pick_operand();
            b_v = pick_operand();
            ref_mul(a_v, b_v, ep, eo);
            run_op(a_v, b_v, 1'b0, p, o, lat);
            total++;
            if (p !== ep || o !== eo) begin
                bad++;
                $display("FAIL rand%0d a=%h b=%h got=%h/%b want=%h/%b", i, a_v, b_v, p, o, ep, eo);
            end
            total++; if (lat !== 32) begin bad++; $display("FAIL rand%0d_latency got=%0d want=32", i, lat); end
            total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL rand%0d_ready got=%b want=1", i, bus.ready); end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_reset_mid();
        test_hold_start();
        test_operand_change();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
